aes128_iter_ctrl: RTL and testbench

Iterative AES-128 encryption controller: accepts one plaintext block per transaction, runs the initial AddRoundKey, nine full rounds and the final round on a single shared round datapath, and presents the ciphertext on a valid/ready output port. It sits between the key-expansion network, which supplies the 1408-bit expanded-key bus, and the block consumer. It replaces free-running, X-checking round sequencing with a deterministic, reset-able FSM and handshakes.

---
 rtl/aes128_iter_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_aes128_iter_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_ctrl.sv
// ---------------------------------------------------------------------------
// aes128_iter_ctrl
//
// Iterative AES-128 encryption controller. One plaintext block is accepted
// per transaction. The initial AddRoundKey happens on the accept edge. Nine
// full rounds and the final round then run on one shared round datapath, one
// round per clock. The ciphertext is held on a valid/ready output port until
// the consumer takes it.
//
// Ports
//   clk          in   1     single clock, rising edge
//   rst          in   1     asynchronous, active-high reset
//   in_valid     in   1     plaintext offered
//   in_ready     out  1     high exactly while the FSM is IDLE
//   in_data      in   128   plaintext, byte 0 at [127:120] (column-major)
//   w            in   1408  expanded key, round-r key at w[1407-128*r -: 128]
//                           (must stay stable while busy is high)
//   out_valid    out  1     ciphertext available (DONE)
//   out_ready    in   1     consumer accepts ciphertext
//   out_data     out  128   state register, valid while out_valid is high
//   busy         out  1     high in RUN and DONE
//   round        out  4     0 in IDLE, 1..10 in RUN, 10 in DONE
//   blk_count    out  16    completed output handshakes, wraps mod 2^16
//   dbg_state_o  out  2     FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds valid (and its data) until that edge. Ready
// depends only on the FSM state, never on valid, so there is no
// combinational path from valid to ready.
// ---------------------------------------------------------------------------
module aes128_iter_ctrl (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_data,
    input  logic [1407:0]   w,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_data,
    output logic            busy,
    output logic [3:0]      round,
    output logic [15:0]     blk_count,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // FIPS-197 S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lu(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows together: output byte (row r, col c) takes the
    // substituted input byte at (row r, col (c+r) mod 4).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        int           r;
        int           c;
        int           src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            r   = i % 4;
            c   = i / 4;
            src = 4 * ((c + r) % 4) + r;
            o[127 - 8*i -: 8] = sbox_lu(s[127 - 8*src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_t         state_q;
    logic [127:0]   st_q;
    logic [3:0]     round_q;
    logic [15:0]    blk_count_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [127:0]   key_r;
    logic [127:0]   sr_d;
    logic [127:0]   full_rnd_d;
    logic [127:0]   final_rnd_d;

    // Round-key mux. In IDLE the counter is 0, so the same mux also gives
    // the whitening key used on the accept edge.
    always_comb begin
        key_r = w[1407 -: 128];
        for (int r = 1; r <= 10; r++) begin
            if (round_q == 4'(r)) begin
                key_r = w[1407 - 128*r -: 128];
            end
        end
    end

    // Shared round datapath: both round flavours start from the same
    // SubBytes/ShiftRows result. Only the full round adds MixColumns.
    always_comb begin
        sr_d        = sub_shift(st_q);
        full_rnd_d  = mix_columns(sr_d) ^ key_r;
        final_rnd_d = sr_d ^ key_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            st_q        <= '0;
            round_q     <= 4'd0;
            blk_count_q <= 16'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        st_q       <= in_data ^ key_r;
                        round_q    <= 4'd1;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (round_q == 4'd10) begin
                        // Final round: counter stays at 10 through DONE.
                        st_q        <= final_rnd_d;
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        st_q    <= full_rnd_d;
                        round_q <= round_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        round_q     <= 4'd0;
                        blk_count_q <= blk_count_q + 16'd1;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    round_q     <= 4'd0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = st_q;
    assign busy        = busy_q;
    assign round       = round_q;
    assign blk_count   = blk_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Bench for aes128_iter_ctrl: table of known-answer vectors, hand-written
// corner sequences, and a random regression against a software AES model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes128_iter_ctrl;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [1407:0] w;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          busy;
  logic [3:0]    round;
  logic [15:0]   blk_count;
  logic [1:0]    dbg_state;

  aes128_iter_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .w           (w),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .round       (round),
    .blk_count   (blk_count),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int            errors = 0;
  int            checks = 0;
  logic [127:0]  exp_q[$];
  logic [15:0]   blk_exp = 16'd0;
  logic [127:0]  snap0, snap1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", out_valid, 1'b0);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        chk("sb_out_data", out_data, e);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, a;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, a);
      if (i == 0) inv = 8'h00;
      sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   wd [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] bus;
    rcon = 8'h01;
    bus = '0;
    for (int i = 0; i < 4; i++) wd[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = wd[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      wd[i] = wd[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) bus[1407 - 32*i -: 32] = wd[i];
    return bus;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1407:0] wb);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127 - 8*(4*c+r) -: 8] ^ wb[1407 - 8*(4*c+r) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
          s[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = s[r][c] ^ wb[1407 - 128*rnd - 8*(4*c+r) -: 8];
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1'b1);
  endtask

  // One complete transaction: accept, ten compute cycles, optional stall
  // in DONE, then one output handshake.
  task automatic run_block(input logic [127:0] pt, input logic [1407:0] wb,
                           input logic [127:0] exp, input int stall, input bit noise);
    logic         ok;
    logic [127:0] od;
    wait_ready();
    in_data = pt; w = wb; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = rand128();
    snap0 = out_data;
    ok = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (round !== 4'(k) || out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
      if (k == 2) snap1 = out_data;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = rand128();
      end
      @(posedge clk); #1;
    end
    chk("round_track", ok, 1'b1);
    chk("out_valid_rise", {out_valid, busy, in_ready, round}, {1'b1, 1'b1, 1'b0, 4'd10});
    od = out_data;
    ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      if (out_valid !== 1'b1 || out_data !== od || in_ready !== 1'b0 || round !== 4'd10 || busy !== 1'b1) ok = 1'b0;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = rand128();
      end
      @(posedge clk); #1;
    end
    if (stall > 0) chk("stall_hold", ok, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    blk_exp = blk_exp + 16'd1;
    chk("idle_after", {out_valid, busy, in_ready, round}, {1'b0, 1'b0, 1'b1, 4'd0});
    chk("blk_count", blk_count, blk_exp);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] st0;
    logic [127:0] st1;
    int           stall;
    bit           noise;
    bit           chk_st;
  } vec_t;

  vec_t vt[4];
  int   acc[3];

  initial begin
    vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00102030405060708090a0b0c0d0e0f0,
              128'h89d810e8855ace682d1843d8cb128fe4, 0, 1'b0, 1'b1};
    vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 128'h0, 128'h0, 2, 1'b1, 1'b0};
    vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 128'h0, 0, 1'b0, 1'b0};
    vt[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h0, 128'h0, 20, 1'b1, 1'b0};

    build_sbox();

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; w = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_round", round, 4'd0);
    chk("rst_blk_count", blk_count, 16'd0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer table, including C.1 intermediate states and a long stall.
    for (int i = 0; i < 4; i++) begin
      run_block(vt[i].pt, expand(vt[i].key), vt[i].ct, vt[i].stall, vt[i].noise);
      if (vt[i].chk_st) begin
        chk("c1_state_after_accept", snap0, vt[i].st0);
        chk("c1_state_after_round1", snap1, vt[i].st1);
      end
    end

    // Back-to-back: in_valid held high, out_ready high.
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      in_data = vt[i].pt;
      w = expand(vt[i].key);
      exp_q.push_back(vt[i].ct);
      @(posedge clk); #1;
      acc[i] = cyc;
    end
    in_valid = 1'b0;
    begin
      int n = 0;
      while (blk_count !== blk_exp + 16'd3 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    blk_exp = blk_exp + 16'd3;
    chk("b2b_blk_count", blk_count, blk_exp);
    chk("b2b_gap_01", acc[1] - acc[0], 12);
    chk("b2b_gap_12", acc[2] - acc[1], 12);
    out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of round 5.
    wait_ready();
    in_data = vt[1].pt; w = expand(vt[1].key); in_valid = 1'b1;
    exp_q.push_back(vt[1].ct);
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      int n = 0;
      while (round !== 4'd5 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("mid_round_reached", round, 4'd5);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_outputs", {in_ready, out_valid, busy, round}, {1'b1, 1'b0, 1'b0, 4'd0});
    chk("midrst_out_data", out_data, 128'h0);
    chk("midrst_blk_count", blk_count, 16'd0);
    blk_exp = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_block(vt[0].pt, expand(vt[0].key), vt[0].ct, 1, 1'b0);

    // Counter wrap through a backdoor preload.
    force dut.blk_count_q = 16'hffff;
    #1;
    release dut.blk_count_q;
    #1;
    chk("wrap_preload", blk_count, 16'hffff);
    blk_exp = 16'hffff;
    run_block(vt[2].pt, expand(vt[2].key), vt[2].ct, 0, 1'b0);
    chk("wrap_zero", blk_count, 16'h0000);

    // Random regression.
    for (int i = 0; i < 1000; i++) begin
      logic [127:0]  k, p;
      logic [1407:0] wb;
      k = rand128();
      p = rand128();
      wb = expand(k);
      run_block(p, wb, aes_ref(p, wb), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
